// File: rtl/rip_mem_arbiter.sv
// rip_mem_arbiter: shares one single-port RAM between fetch and data access.
// Optional perf counters enabled by defining RIP_MEM_ARB_PERF_EN.
module rip_mem_arbiter #(
   parameter int NUM_COL    = 4,
   parameter int COL_WIDTH  = 8,
   parameter int ADDR_WIDTH = 20,
   parameter int DATA_WIDTH = NUM_COL*COL_WIDTH,
   parameter int MAX_STALL  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  if_req,
   input  logic [DATA_WIDTH-1:0] if_addr,
   output logic                  if_gnt,
   output logic                  if_rvalid,
   output logic [DATA_WIDTH-1:0] if_rdata,
   input  logic                  ma_req,
   input  logic [NUM_COL-1:0]    ma_we,
   input  logic [DATA_WIDTH-1:0] ma_addr,
   input  logic [DATA_WIDTH-1:0] ma_wdata,
   output logic                  ma_gnt,
   output logic                  ma_rvalid,
   output logic [DATA_WIDTH-1:0] ma_rdata,
   output logic                  mem_en,
   output logic [NUM_COL-1:0]    mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef RIP_MEM_ARB_PERF_EN
   ,
   output logic [31:0]           conflict_cnt,
   output logic [31:0]           forced_cnt
`endif
);

   typedef enum logic {
      DATA_PRI,
      FETCH_PRI
   } state_t;

   localparam logic [3:0] MAX_S = 4'(MAX_STALL);

   state_t     state_q, state_d;
   logic [3:0] stall_q, stall_d;
   logic       rv_q, own_if_q;

   always_comb begin
      state_d = state_q;
      stall_d = 4'd0;
      if_gnt  = 1'b0;
      ma_gnt  = 1'b0;
      // grants are forced low while reset is held
      if (rst_n) begin
         if (state_q == FETCH_PRI) begin
            if_gnt = if_req;
            ma_gnt = ma_req & ~if_req;
         end else begin
            ma_gnt = ma_req;
            if_gnt = if_req & ~ma_req;
         end
      end
      if (if_req & ~if_gnt)
         stall_d = (stall_q >= MAX_S) ? MAX_S : stall_q + 4'd1;
      unique case (state_q)
         DATA_PRI:  if (stall_d == MAX_S) state_d = FETCH_PRI;
         FETCH_PRI: if (if_gnt | ~if_req) state_d = DATA_PRI;
         default:   state_d = DATA_PRI;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= DATA_PRI;
         stall_q  <= 4'd0;
         rv_q     <= 1'b0;
         own_if_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         stall_q  <= stall_d;
         rv_q     <= if_gnt | ma_gnt;
         own_if_q <= if_gnt;
      end
   end

   always_comb begin
      mem_en    = if_gnt | ma_gnt;
      mem_addr  = '0;
      mem_we    = '0;
      mem_wdata = '0;
      if (if_gnt) begin
         mem_addr = if_addr[ADDR_WIDTH+1:2];
      end else if (ma_gnt) begin
         mem_addr = ma_addr[ADDR_WIDTH+1:2];
         mem_we   = ma_we;
      end
      if (mem_en) mem_wdata = ma_wdata;
   end

   assign if_rvalid = rv_q & own_if_q;
   assign ma_rvalid = rv_q & ~own_if_q;
   assign if_rdata  = if_rvalid ? mem_rdata : '0;
   assign ma_rdata  = ma_rvalid ? mem_rdata : '0;

   // byte offset and high address bits never reach the RAM
   logic unused_addr;
   assign unused_addr = ^{if_addr[1:0], ma_addr[1:0],
                          if_addr[DATA_WIDTH-1:ADDR_WIDTH+2],
                          ma_addr[DATA_WIDTH-1:ADDR_WIDTH+2]};

`ifdef RIP_MEM_ARB_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         conflict_cnt <= 32'd0;
         forced_cnt   <= 32'd0;
      end else begin
         if (if_req & ma_req)
            conflict_cnt <= conflict_cnt + 32'd1;
         if (if_gnt && state_q == FETCH_PRI)
            forced_cnt <= forced_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_rip_mem_arbiter.sv
// tb_rip_mem_arbiter: vector table, directed corners and random traffic
// checked against a behavioural arbiter model with its own RAM image.
module tb_rip_mem_arbiter;

   localparam int MAXS = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req, ma_req;
   logic [31:0] if_addr, ma_addr, ma_wdata;
   logic [3:0]  ma_we;
   logic        if_gnt, if_rvalid, ma_gnt, ma_rvalid, mem_en;
   logic [31:0] if_rdata, ma_rdata, mem_wdata, mem_rdata;
   logic [3:0]  mem_we;
   logic [19:0] mem_addr;
`ifdef RIP_MEM_ARB_PERF_EN
   logic [31:0] conflict_cnt, forced_cnt;
`endif

   always #5 clk = ~clk;

   rip_mem_arbiter #(.MAX_STALL(MAXS)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .ma_req(ma_req), .ma_we(ma_we), .ma_addr(ma_addr),
      .ma_wdata(ma_wdata), .ma_gnt(ma_gnt),
      .ma_rvalid(ma_rvalid), .ma_rdata(ma_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef RIP_MEM_ARB_PERF_EN
      , .conflict_cnt(conflict_cnt), .forced_cnt(forced_cnt)
`endif
   );

   // RAM macro: 1-cycle read latency, old data on read-during-write
   logic [31:0] ram [256];
   always @(posedge clk) begin
      if (mem_en) begin
         mem_rdata <= ram[mem_addr[7:0]];
         for (int b = 0; b < 4; b++)
            if (mem_we[b]) ram[mem_addr[7:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
   end

   function automatic logic [31:0] pat(int i);
      return {8'(i), 8'(i ^ 'h5A), 8'(255 - i), 8'(i + 3)};
   endfunction

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // behavioural model
   int          streak;
   bit          pv, pif;
   logic [31:0] pdata;
   logic [31:0] gold [256];
   int          m_conf, m_forced;
   bit          forced, e_ig, e_mg;
   logic [19:0] e_addr;

   task automatic model_reset();
      streak = 0;
      pv = 0;
      pif = 0;
      pdata = 0;
      m_conf = 0;
      m_forced = 0;
   endtask

   task automatic drive(bit ir, logic [31:0] ia, bit mr, logic [3:0] mw,
                        logic [31:0] ma, logic [31:0] md);
      if_req = ir; if_addr = ia;
      ma_req = mr; ma_we = mw; ma_addr = ma; ma_wdata = md;
   endtask

   // called at posedge+2 with inputs settled; returns at next posedge+1
   task automatic step();
      forced = streak >= MAXS;
      e_ig = if_req && (forced || !ma_req);
      e_mg = ma_req && !e_ig;
      e_addr = e_ig ? if_addr[21:2] : (e_mg ? ma_addr[21:2] : 20'd0);
      check("if_gnt", if_gnt, e_ig);
      check("ma_gnt", ma_gnt, e_mg);
      check("mem_en", mem_en, e_ig | e_mg);
      check("mem_addr", mem_addr, e_addr);
      check("mem_we", mem_we, e_mg ? ma_we : 4'd0);
      if (!e_ig) check("mem_wdata", mem_wdata, e_mg ? ma_wdata : 32'd0);
      check("if_rvalid", if_rvalid, pv && pif);
      check("ma_rvalid", ma_rvalid, pv && !pif);
      check("if_rdata", if_rdata, (pv && pif) ? pdata : 32'd0);
      check("ma_rdata", ma_rdata, (pv && !pif) ? pdata : 32'd0);
      @(posedge clk);
      if (if_req && ma_req) m_conf++;
      if (forced && e_ig) m_forced++;
      streak = (if_req && !e_ig) ? ((streak + 1 > MAXS) ? MAXS : streak + 1) : 0;
      pv = e_ig || e_mg;
      pif = e_ig;
      if (pv) pdata = gold[e_addr[7:0]];
      if (e_mg)
         for (int b = 0; b < 4; b++)
            if (ma_we[b]) gold[e_addr[7:0]][b*8 +: 8] = ma_wdata[b*8 +: 8];
      #1;
   endtask

   typedef struct {
      bit          ir;
      logic [31:0] ia;
      bit          mr;
      logic [3:0]  mw;
      logic [31:0] ma;
      logic [31:0] md;
      bit          eig;
      bit          emg;
      logic [19:0] eaddr;
      logic [3:0]  ewe;
   } vec_t;

   vec_t tbl [11];

   initial begin
      logic [31:0] w;
      logic [31:0] c0, f0;
      c0 = 0;
      f0 = 0;
      for (int i = 0; i < 256; i++) begin
         ram[i] = pat(i);
         gold[i] = pat(i);
      end
      mem_rdata = 0;
      model_reset();

      tbl[0]  = '{1, 32'h100, 0, 4'h0, 32'h0,   32'h0,        1, 0, 20'h40, 4'h0};
      tbl[1]  = '{0, 32'h0,   1, 4'h8, 32'h203, 32'hAB000000, 0, 1, 20'h80, 4'h8};
      tbl[2]  = '{1, 32'h200, 0, 4'h0, 32'h0,   32'h0,        1, 0, 20'h80, 4'h0};
      tbl[3]  = '{0, 32'h0,   0, 4'h0, 32'h0,   32'h0,        0, 0, 20'h0,  4'h0};
      for (int i = 4; i < 10; i++)
         tbl[i] = '{1, 32'h104, 1, 4'h0, 32'h208, 32'h0,
                    (i == 8), (i != 8), (i == 8) ? 20'h41 : 20'h82, 4'h0};
      tbl[10] = '{0, 32'h0,   0, 4'h0, 32'h0,   32'h0,        0, 0, 20'h0,  4'h0};

      // reset with both requests active: everything must stay low
      rst_n = 1'b0;
      drive(1, 32'h100, 1, 4'hF, 32'h204, 32'hFFFFFFFF);
      #3;
      check("rst_if_gnt", if_gnt, 0);
      check("rst_ma_gnt", ma_gnt, 0);
      check("rst_mem_en", mem_en, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_rvalid", {if_rvalid, ma_rvalid}, 0);
      drive(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 11; i++) begin
         drive(tbl[i].ir, tbl[i].ia, tbl[i].mr, tbl[i].mw, tbl[i].ma, tbl[i].md);
         #1;
         check($sformatf("vec%0d_if_gnt", i), if_gnt, tbl[i].eig);
         check($sformatf("vec%0d_ma_gnt", i), ma_gnt, tbl[i].emg);
         check($sformatf("vec%0d_mem_addr", i), mem_addr, tbl[i].eaddr);
         check($sformatf("vec%0d_mem_we", i), mem_we, tbl[i].ewe);
`ifdef RIP_MEM_ARB_PERF_EN
         if (i == 4) begin
            c0 = conflict_cnt;
            f0 = forced_cnt;
         end
`endif
         step();
         if (i == 2) begin
            w = pat('h80);
            check("store_merge", if_rdata, {8'hAB, w[23:0]});
         end
`ifdef RIP_MEM_ARB_PERF_EN
         if (i == 9) begin
            check("perf_conflict", conflict_cnt - c0, 6);
            check("perf_forced", forced_cnt - f0, 1);
         end
`endif
      end

      // back-to-back alternating fetch / data reads
      for (int k = 0; k < 8; k++) begin
         if (k % 2 == 0) drive(1, 32'h300 + 32'(k*4), 0, 0, 0, 0);
         else drive(0, 0, 1, 4'h0, 32'h340 + 32'(k*4), 0);
         #1;
         check($sformatf("b2b%0d_mem_en", k), mem_en, 1);
         step();
      end

      // reset in the cycle after a grant
      drive(1, 32'h0, 1, 4'h0, 32'h3FC, 0);
      #1;
      step();
      #1;
      step();
      rst_n = 1'b0;
      #1;
      check("mrst_ma_rvalid", ma_rvalid, 0);
      check("mrst_if_rvalid", if_rvalid, 0);
      check("mrst_gnt", {if_gnt, ma_gnt}, 0);
      check("mrst_mem_en", mem_en, 0);
      check("mrst_ma_rdata", ma_rdata, 0);
      model_reset();
      drive(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_rvalid", {if_rvalid, ma_rvalid}, 0);
      drive(1, 32'h10, 1, 4'h0, 32'h20, 0);
      for (int k = 0; k < 6; k++) begin
         #1;
         check($sformatf("post_rst%0d_if_gnt", k), if_gnt, k == 4);
         step();
      end
      drive(0, 0, 0, 0, 0, 0);
      #1;
      step();

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         if (if_req && !e_ig) begin
            if ($urandom_range(0, 15) == 0) if_req = 0;
         end else begin
            if_req = ($urandom_range(0, 9) < 6);
            if_addr = $urandom_range(0, 1023);
         end
         if (ma_req && !e_mg) begin
            if ($urandom_range(0, 15) == 0) ma_req = 0;
         end else begin
            ma_req = ($urandom_range(0, 9) < 6);
            ma_addr = $urandom_range(0, 1023);
            ma_we = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15));
            ma_wdata = $urandom;
         end
         #1;
         step();
      end

`ifdef RIP_MEM_ARB_PERF_EN
      check("perf_conflict_total", conflict_cnt, m_conf);
      check("perf_forced_total", forced_cnt, m_forced);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rip_mem_arbiter.md
Name: rip_mem_arbiter

Overview:
- Shares one single-port, word-organised synchronous RAM between the instruction-fetch requester and the memory-access requester of the rip core.
- Sits between the IF/MA pipeline stages and the RAM macro.
- Decides the owner of each cycle and drives RAM enable, byte-write strobes, word address and write data.
- Steers the 1-cycle-latency read data back to the owner with a valid pulse.
- Data access has default priority; an anti-starvation counter guarantees fetch progress.

Parameters:
- NUM_COL, 4, byte lanes per word
- COL_WIDTH, 8, bits per lane
- ADDR_WIDTH, 20, RAM word-address width
- DATA_WIDTH, NUM_COL*COL_WIDTH, data/byte-address port width
- MAX_STALL, 4, consecutive denied fetch cycles before fetch is forced to win (1..15)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch read request
- if_addr  in  DATA_WIDTH  fetch byte address
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  fetch data valid
- if_rdata  out  DATA_WIDTH  fetch read word
- ma_req  in  1  data request
- ma_we  in  NUM_COL  byte-write strobes (all 0 = read)
- ma_addr  in  DATA_WIDTH  data byte address
- ma_wdata  in  DATA_WIDTH  lane-aligned write data
- ma_gnt  out  1  data request accepted this cycle
- ma_rvalid  out  1  data read or write completed
- ma_rdata  out  DATA_WIDTH  data read word
- mem_en  out  1  RAM access enable
- mem_we  out  NUM_COL  RAM byte-write enables
- mem_addr  out  ADDR_WIDTH  RAM word address
- mem_wdata  out  DATA_WIDTH  RAM write data
- mem_rdata  in  DATA_WIDTH  RAM read data, valid the cycle after mem_en

Behaviour:
- Reset: clk and asynchronous active-low rst_n. While rst_n=0 all outputs are 0, the FSM is in DATA_PRI and stall_cnt=0. Any in-flight response is dropped: no rvalid follows a reset.
- Grants are combinational and issued in the same cycle as the request. Requesters hold req, addr, we and wdata stable until they see gnt.
- At most one grant per cycle; if_gnt and ma_gnt are never both 1.
- FSM state DATA_PRI:
  - ma_req=1 → ma_gnt=1.
  - Otherwise if_req=1 → if_gnt=1.
- FSM state FETCH_PRI:
  - if_req=1 → if_gnt=1.
  - Otherwise ma_req=1 → ma_gnt=1.
- stall_cnt (4 bits):
  - Increments when if_req=1 and if_gnt=0.
  - Clears when if_gnt=1 or if_req=0.
  - Saturates at MAX_STALL.
- FSM transitions:
  - DATA_PRI → FETCH_PRI on the edge where stall_cnt reaches MAX_STALL.
  - FETCH_PRI → DATA_PRI on the edge after if_gnt=1 or if_req=0; it lasts for exactly one fetch win.
- RAM drive:
  - mem_en = if_gnt | ma_gnt.
  - mem_addr = granted addr[ADDR_WIDTH+1:2]; byte offset bits [1:0] are ignored.
  - mem_we = ma_we when ma_gnt, else 0; fetch never writes.
  - mem_wdata = ma_wdata.
  - When idle, mem_addr, mem_we and mem_wdata are 0.
- Response path:
  - A registered owner tag and a valid bit record each grant.
  - if_rvalid / ma_rvalid are 1 exactly one cycle after the matching grant.
  - ma_rvalid pulses for writes too (write acknowledge).
  - x_rdata = mem_rdata while x_rvalid=1, else 0. Write responses return whatever the RAM outputs.
- Back-to-back: a new grant can be issued in the same cycle that the previous rvalid is high, giving full throughput of 1 access/cycle.
- Simultaneous if_req and ma_req: the loser keeps req asserted, gets no gnt and no rvalid, and stall_cnt advances for fetch.
- Deasserting a req that has not been granted is legal and has no side effects.

Optional Feature:
- Macro RIP_MEM_ARB_PERF_EN.
- When defined, adds output ports:
  - conflict_cnt  out  32: counts cycles with if_req & ma_req.
  - forced_cnt  out  32: counts FETCH_PRI grants to fetch.
- Both counters reset to 0 on rst_n=0 and wrap modulo 2^32.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Fetch only: if_req=1, if_addr=0x100 → if_gnt same cycle, mem_addr=0x40, mem_we=0; next cycle if_rvalid=1, if_rdata = RAM word 0x40.
- Byte store: ma_req=1, ma_addr=0x203, ma_we=4'b1000, ma_wdata=0xAB000000 → mem_we=4'b1000, mem_addr=0x80; next cycle ma_rvalid=1. A subsequent fetch of 0x200 returns 0xAB in byte 3 with the other bytes unchanged.
- Conflict: if_req and ma_req held high for 6 cycles with MAX_STALL=4 → ma_gnt on cycles 0–3, if_gnt on cycle 4 (FETCH_PRI), ma_gnt on cycle 5. Grants are never simultaneous.
- Back-to-back: alternating fetch and data reads for 8 cycles → mem_en=1 every cycle, each rvalid on the correct port one cycle after its grant, with the correct data.
- Reset mid-access: rst_n low in the cycle after a grant → no rvalid is produced, all outputs are 0, the FSM is in DATA_PRI and stall_cnt=0 after release.
- PERF (RIP_MEM_ARB_PERF_EN defined): the conflict scenario above → conflict_cnt=6, forced_cnt=1.
